// File: rtl/sequence_player_if.sv
// Bundles the pattern-loading, playback-status and peripheral-command signals of sequence_player.
`default_nettype none

interface sequence_player_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push;
    logic [1:0]    push_color;
    logic          start;
    logic          clear;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;
    logic          led_strobe;
    logic [1:0]    led_color;
    logic          led_on;
    logic          audio_strobe;
    logic [1:0]    audio_color;
    logic          audio_on;

    modport master (
        output push, push_color, start, clear,
        input  busy, done, count, overflow,
        input  led_strobe, led_color, led_on,
        input  audio_strobe, audio_color, audio_on
    );

    modport slave (
        input  push, push_color, start, clear,
        output busy, done, count, overflow,
        output led_strobe, led_color, led_on,
        output audio_strobe, audio_color, audio_on
    );
endinterface

`default_nettype wire

// File: rtl/sequence_player.sv
// ============================================================================
// sequence_player: stores a colour pattern and plays it back as timed on/off
// write commands to an LED flasher (and tone generator with SEQUENCE_PLAYER_AUDIO_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sequence_player #(
    parameter int DEPTH      = 16,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    sequence_player_if.slave bus_if
);
    localparam int IW   = $clog2(DEPTH);
    localparam int CW   = IW + 1;
    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [IW-1:0]   index_q, index_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;
    logic            strobe_q, strobe_d;
    logic [1:0]      color_q, color_d;
    logic            on_q, on_d;
    logic            wr_en;
    logic [1:0]      mem_q [DEPTH];

    logic [IW-1:0]   next_index;
    logic            more_entries;
    logic [1:0]      cur_color;

    assign next_index   = index_q + IW'(1);
    assign more_entries = ({1'b0, index_q} + CW'(1)) < count_q;
    assign cur_color    = mem_q[index_q];

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        index_d    = index_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        strobe_d   = 1'b0;
        color_d    = color_q;
        on_d       = on_q;
        wr_en      = 1'b0;

        if (bus_if.clear) begin
            state_d    = S_IDLE;
            index_d    = '0;
            count_d    = '0;
            busy_d     = 1'b0;
            overflow_d = 1'b0;
            // Aborting while lit must switch the peripherals off.
            if (state_q == S_ON) begin
                strobe_d = 1'b1;
                on_d     = 1'b0;
                color_d  = cur_color;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus_if.start) begin
                        if (count_q != '0) begin
                            state_d  = S_ON;
                            index_d  = '0;
                            timer_d  = ON_LOAD;
                            busy_d   = 1'b1;
                            strobe_d = 1'b1;
                            on_d     = 1'b1;
                            color_d  = mem_q[0];
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (bus_if.push) begin
                        if (count_q == FULL) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                S_ON: begin
                    if (timer_q == '0) begin
                        state_d  = S_GAP;
                        timer_d  = OFF_LOAD;
                        strobe_d = 1'b1;
                        on_d     = 1'b0;
                        color_d  = cur_color;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_GAP: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TW'(1);
                    end else if (more_entries) begin
                        state_d  = S_ON;
                        index_d  = next_index;
                        timer_d  = ON_LOAD;
                        strobe_d = 1'b1;
                        on_d     = 1'b1;
                        color_d  = mem_q[next_index];
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            index_q    <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            strobe_q   <= 1'b0;
            color_q    <= 2'b00;
            on_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            index_q    <= index_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            strobe_q   <= strobe_d;
            color_q    <= color_d;
            on_q       <= on_d;
        end
    end

    // Pattern storage is deliberately not reset; count gates every read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[count_q[IW-1:0]] <= bus_if.push_color;
        end
    end

    assign bus_if.busy       = busy_q;
    assign bus_if.done       = done_q;
    assign bus_if.count      = count_q;
    assign bus_if.overflow   = overflow_q;
    assign bus_if.led_strobe = strobe_q;
    assign bus_if.led_color  = color_q;
    assign bus_if.led_on     = on_q;

`ifdef SEQUENCE_PLAYER_AUDIO_EN
    assign bus_if.audio_strobe = strobe_q;
    assign bus_if.audio_color  = color_q;
    assign bus_if.audio_on     = on_q;
`else
    assign bus_if.audio_strobe = 1'b0;
    assign bus_if.audio_color  = 2'b00;
    assign bus_if.audio_on     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player with DEPTH=4, ON_CYCLES=4, OFF_CYCLES=2.
`default_nettype none

module tb_sequence_player;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sequence_player_if #(.DEPTH(4)) bus_if ();

    sequence_player #(
        .DEPTH     (4),
        .ON_CYCLES (4),
        .OFF_CYCLES(2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_if(bus_if)
    );

    typedef struct {
        int         cyc;
        logic       strobe;
        logic       on;
        logic [1:0] color;
        logic       done;
        logic       busy;
    } ev_t;

    ev_t evq[$];
    ev_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_strobe(input int c, input logic on, input logic [1:0] col, input logic busy);
        ev_t e;
        e.cyc = c; e.strobe = 1'b1; e.on = on; e.color = col; e.done = 1'b0; e.busy = busy;
        evq.push_back(e);
    endtask

    task automatic exp_done(input int c);
        ev_t e;
        e.cyc = c; e.strobe = 1'b0; e.on = 1'b0; e.color = 2'b00; e.done = 1'b1; e.busy = 1'b0;
        evq.push_back(e);
    endtask

    // Monitor: every strobe or done the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (!rst && (bus_if.led_strobe || bus_if.done)) begin
            if (evq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: strobe=%0d done=%0d at cycle %0d, required none",
                         bus_if.led_strobe, bus_if.done, cyc);
            end else begin
                mon_e = evq.pop_front();
                chk("event_cycle", cyc, mon_e.cyc);
                chk("event_strobe", bus_if.led_strobe, mon_e.strobe);
                chk("event_done", bus_if.done, mon_e.done);
                chk("event_busy", bus_if.busy, mon_e.busy);
                if (mon_e.strobe) begin
                    chk("event_led_on", bus_if.led_on, mon_e.on);
                    chk("event_led_color", bus_if.led_color, mon_e.color);
                end
            end
        end
`ifdef SEQUENCE_PLAYER_AUDIO_EN
        chk("audio_strobe", bus_if.audio_strobe, bus_if.led_strobe);
        chk("audio_color", bus_if.audio_color, bus_if.led_color);
        chk("audio_on", bus_if.audio_on, bus_if.led_on);
`else
        chk("audio_strobe", bus_if.audio_strobe, 1'b0);
        chk("audio_color", bus_if.audio_color, 2'b00);
        chk("audio_on", bus_if.audio_on, 1'b0);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [1:0] col);
        bus_if.push = 1'b1;
        bus_if.push_color = col;
        tick();
        bus_if.push = 1'b0;
    endtask

    task automatic do_clear();
        bus_if.clear = 1'b1;
        tick();
        bus_if.clear = 1'b0;
    endtask

    task automatic pulse_start();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic play_two(input logic [1:0] a, input logic [1:0] b);
        int t;
        t = cyc;
        exp_strobe(t + 1, 1'b1, a, 1'b1);
        exp_strobe(t + 5, 1'b0, a, 1'b1);
        exp_strobe(t + 7, 1'b1, b, 1'b1);
        exp_strobe(t + 11, 1'b0, b, 1'b1);
        exp_done(t + 13);
        pulse_start();
        repeat (11) tick();
        chk("busy_last_gap", bus_if.busy, 1'b1);
        repeat (3) tick();
        chk("busy_after_done", bus_if.busy, 1'b0);
    endtask

    task automatic play_one(input logic [1:0] a, input logic push_mid);
        int t;
        t = cyc;
        exp_strobe(t + 1, 1'b1, a, 1'b1);
        exp_strobe(t + 5, 1'b0, a, 1'b1);
        exp_done(t + 7);
        pulse_start();
        if (push_mid) do_push(2'b10);
        else tick();
        repeat (7) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus_if.push = 1'b0;
        bus_if.push_color = 2'b00;
        bus_if.start = 1'b0;
        bus_if.clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_busy", bus_if.busy, 1'b0);
        chk("reset_done", bus_if.done, 1'b0);
        chk("reset_count", bus_if.count, 3'd0);
        chk("reset_overflow", bus_if.overflow, 1'b0);
        chk("reset_led_strobe", bus_if.led_strobe, 1'b0);
        chk("reset_led_color", bus_if.led_color, 2'b00);
        chk("reset_led_on", bus_if.led_on, 1'b0);
        tick();

        // Two-colour pattern, then replay of the same buffer.
        do_push(2'b01);
        do_push(2'b11);
        chk("count_two", bus_if.count, 3'd2);
        play_two(2'b01, 2'b11);
        chk("count_after_play", bus_if.count, 3'd2);
        play_two(2'b01, 2'b11);
        chk("count_after_replay", bus_if.count, 3'd2);

        // Start on an empty buffer: done only, never busy.
        do_clear();
        chk("count_cleared", bus_if.count, 3'd0);
        t = cyc;
        exp_done(t + 1);
        pulse_start();
        chk("empty_busy_t1", bus_if.busy, 1'b0);
        tick();
        chk("empty_busy_t2", bus_if.busy, 1'b0);
        tick();

        // Fill past capacity.
        do_push(2'b00);
        do_push(2'b01);
        do_push(2'b10);
        do_push(2'b11);
        chk("count_full", bus_if.count, 3'd4);
        chk("overflow_not_yet", bus_if.overflow, 1'b0);
        do_push(2'b00);
        chk("count_still_full", bus_if.count, 3'd4);
        chk("overflow_set", bus_if.overflow, 1'b1);
        do_clear();
        chk("count_after_clear", bus_if.count, 3'd0);
        chk("overflow_after_clear", bus_if.overflow, 1'b0);
        tick();

        // Clear during ON aborts with an off strobe and no done.
        do_push(2'b10);
        t = cyc;
        exp_strobe(t + 1, 1'b1, 2'b10, 1'b1);
        exp_strobe(t + 3, 1'b0, 2'b10, 1'b0);
        pulse_start();
        tick();
        do_clear();
        chk("abort_busy", bus_if.busy, 1'b0);
        chk("abort_count", bus_if.count, 3'd0);
        repeat (8) tick();

        // Start beats a simultaneous push; push while busy is ignored.
        do_push(2'b11);
        t = cyc;
        exp_strobe(t + 1, 1'b1, 2'b11, 1'b1);
        exp_strobe(t + 5, 1'b0, 2'b11, 1'b1);
        exp_done(t + 7);
        bus_if.start = 1'b1;
        bus_if.push = 1'b1;
        bus_if.push_color = 2'b00;
        tick();
        bus_if.start = 1'b0;
        bus_if.push = 1'b0;
        repeat (8) tick();
        chk("count_start_beats_push", bus_if.count, 3'd1);
        play_one(2'b11, 1'b1);
        chk("count_push_while_busy", bus_if.count, 3'd1);
        chk("overflow_push_while_busy", bus_if.overflow, 1'b0);

        // Asynchronous reset mid-playback: no off strobe.
        t = cyc;
        exp_strobe(t + 1, 1'b1, 2'b11, 1'b1);
        pulse_start();
        tick();
        rst = 1'b1;
        #1;
        chk("midreset_busy", bus_if.busy, 1'b0);
        chk("midreset_count", bus_if.count, 3'd0);
        chk("midreset_led_strobe", bus_if.led_strobe, 1'b0);
        chk("midreset_led_on", bus_if.led_on, 1'b0);
        chk("midreset_led_color", bus_if.led_color, 2'b00);
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();

        chk("pending_events", evq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 Parameter DEPTH, default 16: pattern buffer entries (power of two, 2..64).
REQ-002 Parameter ON_CYCLES, default 25000000: clocks each color is lit/sounded (>=2).
REQ-003 Parameter OFF_CYCLES, default 12500000: clocks of silence between colors (>=1).
REQ-004 clock  in  1  single clock, all logic on rising edge; reset is asynchronous and active-high.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 push  in  1  append push_color to buffer this cycle.
REQ-007 push_color  in  2  color code 00 red, 01 blue, 10 green, 11 yellow.
REQ-008 start  in  1  begin playback of stored pattern.
REQ-009 clear  in  1  empty buffer; abort playback.
REQ-010 busy  out  1  high from accepted start until playback ends.
REQ-011 done  out  1  one-cycle pulse when playback completes normally.
REQ-012 count  out  log2(DEPTH)+1  entries stored.
REQ-013 overflow  out  1  sticky; set by push while full, cleared by clear.
REQ-014 led_strobe, led_color[1:0], led_on  out  1/2/1  one-cycle write command to the LED flasher.
REQ-015 audio_strobe, audio_color[1:0], audio_on  out  1/2/1  one-cycle write command to the tone generator.

Function
REQ-016 All outputs registered; FSM states IDLE, ON, GAP.
REQ-017 IDLE: push with count<DEPTH stores push_color at index count, count+1 next cycle.
REQ-018 Push with count==DEPTH: ignored, overflow set. Push while busy: ignored, overflow unchanged.
REQ-019 IDLE, start, count>0: next cycle state ON, index=0, busy=1, led_strobe=1, led_on=1, led_color=buf[0].
REQ-020 IDLE, start, count==0: next cycle done=1 for one cycle, no strobes, busy stays 0.
REQ-021 ON lasts exactly ON_CYCLES cycles counting the strobe cycle; on the following cycle state GAP, led_strobe=1, led_on=0, led_color=current color.
REQ-022 GAP lasts exactly OFF_CYCLES cycles counting the off-strobe cycle; then if index<count-1, index+1 and ON entered as in REQ-019 with buf[index]; else IDLE, busy=0, done=1 same cycle.
REQ-023 Strobes are single-cycle; led_color/led_on hold their last value between strobes.
REQ-024 start while busy ignored; playback does not modify buffer or count; pattern replayable.
REQ-025 clear (any state): next cycle count=0, overflow=0, IDLE, busy=0, no done; if aborted in ON, an off strobe (on=0) is issued that cycle.
REQ-026 Simultaneous in IDLE: clear beats start and push; start beats push (push dropped, overflow unchanged).
REQ-027 Cycle counter width ceil(log2(max(ON_CYCLES,OFF_CYCLES)))+1, saturation-free, reloaded at each state entry.

Reset
REQ-028 reset asserted: immediately state IDLE, count=0, index=0, busy=0, done=0, overflow=0, all strobe/color/on outputs 0.
REQ-029 Buffer contents not reset; unreadable until rewritten since count=0.
REQ-030 reset mid-playback aborts with no off strobe; downstream peripherals are reset by the same signal.

Configuration
REQ-031 Macro SEQUENCE_PLAYER_AUDIO_EN defined: audio_strobe/color/on mirror led_strobe/color/on cycle-for-cycle.
REQ-032 Not defined: audio_strobe, audio_color, audio_on tied 0; LED behaviour unchanged.

Verification (ON_CYCLES=4, OFF_CYCLES=2, DEPTH=4, audio enabled)
REQ-033 Push 01,11 then start -> led strobes: on/01 at T+1, off/01 at T+5, on/11 at T+7, off/11 at T+11, done pulse at T+13, busy high T+1..T+12.
REQ-034 Five pushes into empty buffer -> count=4, overflow=1; clear -> count=0, overflow=0 next cycle.
REQ-035 start with count=0 -> done at T+1, no strobe, busy never high.
REQ-036 Push 10, start, clear at T+2 -> off strobe color 10 at T+3, busy=0, count=0, no done.
REQ-037 start and push same IDLE cycle with count=1 -> one color played, count stays 1; repeat start -> identical strobe sequence.
REQ-038 Macro undefined, scenario REQ-033 -> audio outputs constant 0, LED trace identical.
